// File: rtl/elevator_scheduler.sv
// elevator_scheduler: SCAN-policy request scheduler for a single elevator car.
// Latches hall and cabin presses into a pending-floor mask and sequences the
// car through move-up, move-down and door-dwell phases.

module elevator_scheduler #(
    parameter int FLOORS  = 8,
    parameter int FLOOR_W = 3,
    parameter int DWELL   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               off_btn,
    input  logic [FLOOR_W-1:0] position,
    input  logic               at_floor,
    input  logic               floor_req_valid,
    input  logic [FLOOR_W-1:0] floor_req,
    input  logic               cabin_req_valid,
    input  logic [FLOOR_W-1:0] cabin_req,
    output logic               motor_up,
    output logic               motor_down,
    output logic               door,
    output logic [FLOOR_W-1:0] target,
    output logic [FLOORS-1:0]  pending,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    localparam int                 CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]   DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(FLOORS - 1);

    state_t               state, state_next;
    logic                 last_dir, last_dir_next;
    logic [CNT_W-1:0]     dwell_cnt, dwell_next;
    logic [FLOORS-1:0]    pending_q, pending_next;
    logic [FLOOR_W-1:0]   target_q, target_next;

    logic [FLOORS-1:0]    pos_mask, above_mask, below_mask;
    logic [FLOORS-1:0]    req_mask, latch_mask;
    logic [FLOOR_W-1:0]   lo_above, hi_below;
    logic                 pend_here, any_above, any_below;
    logic                 door_reload, clear_here;

    // One-hot decode of a floor index; indices at or beyond FLOORS decode to zero
    function automatic logic [FLOORS-1:0] decode_floor(input logic [FLOOR_W-1:0] idx);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) == idx) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Position-relative masks and nearest pending stops above and below the car
    always_comb begin
        pos_mask   = '0;
        above_mask = '0;
        below_mask = '0;
        lo_above   = position;
        hi_below   = position;
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) == position) pos_mask[i]   = 1'b1;
            if (FLOOR_W'(i) >  position) above_mask[i] = 1'b1;
            if (FLOOR_W'(i) <  position) below_mask[i] = 1'b1;
        end
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pending_q[i] && (FLOOR_W'(i) > position)) lo_above = FLOOR_W'(i);
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && (FLOOR_W'(i) < position)) hi_below = FLOOR_W'(i);
        end
    end

    assign pend_here = |(pending_q & pos_mask);
    assign any_above = |(pending_q & above_mask);
    assign any_below = |(pending_q & below_mask);

    // Incoming presses; a press for the floor the door is already open at only extends dwell
    always_comb begin
        req_mask = '0;
        if (floor_req_valid) req_mask = req_mask | decode_floor(floor_req);
        if (cabin_req_valid) req_mask = req_mask | decode_floor(cabin_req);
        latch_mask  = req_mask;
        door_reload = 1'b0;
        if (state == DOOR_OPEN && at_floor) begin
            latch_mask  = req_mask & ~pos_mask;
            door_reload = !off_btn && (|(req_mask & pos_mask));
        end
    end

    // SCAN next-state decision, direction memory and door dwell countdown
    always_comb begin
        state_next    = state;
        last_dir_next = last_dir;
        dwell_next    = dwell_cnt;
        clear_here    = 1'b0;
        case (state)
            IDLE: begin
                if (!off_btn) begin
                    if (at_floor && pend_here) begin
                        state_next = DOOR_OPEN;
                        clear_here = 1'b1;
                    end else if (any_above && any_below) begin
                        state_next = last_dir ? MOVE_UP : MOVE_DOWN;
                    end else if (any_above) begin
                        state_next = MOVE_UP;
                    end else if (any_below) begin
                        state_next = MOVE_DOWN;
                    end
                end
            end
            MOVE_UP: begin
                if (at_floor && (pend_here || off_btn)) begin
                    state_next    = DOOR_OPEN;
                    clear_here    = 1'b1;
                    last_dir_next = 1'b1;
                end else if (position == TOP_FLOOR) begin
                    state_next = IDLE;
                end else if (at_floor && !any_above) begin
                    state_next = IDLE;
                end
            end
            MOVE_DOWN: begin
                if (at_floor && (pend_here || off_btn)) begin
                    state_next    = DOOR_OPEN;
                    clear_here    = 1'b1;
                    last_dir_next = 1'b0;
                end else if (position == '0) begin
                    state_next = IDLE;
                end else if (at_floor && !any_below) begin
                    state_next = IDLE;
                end
            end
            DOOR_OPEN: begin
                if (door_reload) begin
                    dwell_next = DWELL_LOAD;
                end else if (dwell_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    dwell_next = dwell_cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (state != DOOR_OPEN && state_next == DOOR_OPEN) dwell_next = DWELL_LOAD;
    end

    // Pending mask update: new presses set bits, a stop clears its bit and wins over a same-edge press
    always_comb begin
        pending_next = '0;
        if (!off_btn) begin
            pending_next = (pending_q | latch_mask) & ~(clear_here ? pos_mask : '0);
        end
    end

    // Next stop shown to the datapath, chosen from the direction being entered
    always_comb begin
        target_next = position;
        case (state_next)
            MOVE_UP:   target_next = lo_above;
            MOVE_DOWN: target_next = hi_below;
            default:   target_next = position;
        endcase
    end

    // State, direction, dwell, pending and target registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            last_dir  <= 1'b1;
            dwell_cnt <= '0;
            pending_q <= '0;
            target_q  <= '0;
        end else begin
            state     <= state_next;
            last_dir  <= last_dir_next;
            dwell_cnt <= dwell_next;
            pending_q <= pending_next;
            target_q  <= target_next;
        end
    end

    assign motor_up   = (state == MOVE_UP);
    assign motor_down = (state == MOVE_DOWN);
    assign door       = (state == DOOR_OPEN);
    assign target     = target_q;
    assign pending    = pending_q;
    assign busy       = (state != IDLE) || (pending_q != '0);

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: directed checks of request capture, SCAN ordering,
// door dwell, service disable and reset for elevator_scheduler.

module tb_elevator_scheduler;

    localparam int FLOORS  = 8;
    localparam int FLOOR_W = 4;
    localparam int DWELL   = 4;

    logic               clock;
    logic               reset;
    logic               off_btn;
    logic [FLOOR_W-1:0] position;
    logic               at_floor;
    logic               floor_req_valid;
    logic [FLOOR_W-1:0] floor_req;
    logic               cabin_req_valid;
    logic [FLOOR_W-1:0] cabin_req;
    logic               motor_up;
    logic               motor_down;
    logic               door;
    logic [FLOOR_W-1:0] target;
    logic [FLOORS-1:0]  pending;
    logic               busy;

    int tests_run = 0;
    int tests_failed = 0;

    elevator_scheduler #(
        .FLOORS (FLOORS),
        .FLOOR_W(FLOOR_W),
        .DWELL  (DWELL)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .off_btn        (off_btn),
        .position       (position),
        .at_floor       (at_floor),
        .floor_req_valid(floor_req_valid),
        .floor_req      (floor_req),
        .cabin_req_valid(cabin_req_valid),
        .cabin_req      (cabin_req),
        .motor_up       (motor_up),
        .motor_down     (motor_down),
        .door           (door),
        .target         (target),
        .pending        (pending),
        .busy           (busy)
    );

    // Free-running 10-unit clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one cycle of request strobes, then withdraw them
    task automatic applyStimulus(input logic fv, input logic [FLOOR_W-1:0] f,
                                 input logic cv, input logic [FLOOR_W-1:0] c);
        floor_req_valid = fv;
        floor_req       = f;
        cabin_req_valid = cv;
        cabin_req       = c;
        tick();
        floor_req_valid = 1'b0;
        cabin_req_valid = 1'b0;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence
    initial begin
        reset = 1'b1; off_btn = 1'b0; position = '0; at_floor = 1'b0;
        floor_req_valid = 1'b0; floor_req = '0; cabin_req_valid = 1'b0; cabin_req = '0;
        tick();
        checkOutput("rst.motor_up",   32'(motor_up),   0);
        checkOutput("rst.motor_down", 32'(motor_down), 0);
        checkOutput("rst.door",       32'(door),       0);
        checkOutput("rst.target",     32'(target),     0);
        checkOutput("rst.pending",    32'(pending),    0);
        checkOutput("rst.busy",       32'(busy),       0);

        // Single cabin request from floor 1 to floor 5
        reset = 1'b0; position = 4'd1; at_floor = 1'b1;
        tick();
        checkOutput("idle.busy", 32'(busy), 0);
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd5);
        checkOutput("req5.pending",  32'(pending),  32'h20);
        checkOutput("req5.motor_up", 32'(motor_up), 0);
        checkOutput("req5.busy",     32'(busy),     1);
        tick();
        checkOutput("go5.motor_up", 32'(motor_up), 1);
        checkOutput("go5.target",   32'(target),   5);
        checkOutput("go5.door",     32'(door),     0);
        at_floor = 1'b0; position = 4'd2;
        tick();
        position = 4'd3; at_floor = 1'b1;
        tick();
        checkOutput("pass3.motor_up", 32'(motor_up), 1);
        at_floor = 1'b0; position = 4'd4;
        tick();
        position = 4'd5; at_floor = 1'b1;
        tick();
        checkOutput("arr5.motor_up", 32'(motor_up), 0);
        checkOutput("arr5.door",     32'(door),     1);
        checkOutput("arr5.pending",  32'(pending),  0);
        checkOutput("arr5.target",   32'(target),   5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("dwell5.door", 32'(door), 1);
        end
        tick();
        checkOutput("close5.door", 32'(door), 0);
        checkOutput("close5.busy", 32'(busy), 0);

        // SCAN: moving up from 2 with {4,6}, hall call 1 arrives en route
        position = 4'd2; at_floor = 1'b1;
        applyStimulus(1'b1, 4'd6, 1'b1, 4'd4);
        checkOutput("scan.pending0", 32'(pending), 32'h50);
        tick();
        checkOutput("scan.up1",     32'(motor_up), 1);
        checkOutput("scan.target4", 32'(target),   4);
        at_floor = 1'b0;
        applyStimulus(1'b1, 4'd1, 1'b0, 4'd0);
        checkOutput("scan.pending1", 32'(pending), 32'h52);
        position = 4'd3; at_floor = 1'b1;
        tick();
        checkOutput("scan.pass3", 32'(motor_up), 1);
        position = 4'd4;
        tick();
        checkOutput("scan.stop4.door",    32'(door),    1);
        checkOutput("scan.stop4.pending", 32'(pending), 32'h42);
        checkOutput("scan.stop4.target",  32'(target),  4);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("scan.dwell4.door", 32'(door), 1);
        tick();
        checkOutput("scan.idle4.door",     32'(door),     0);
        checkOutput("scan.idle4.motor_up", 32'(motor_up), 0);
        checkOutput("scan.idle4.busy",     32'(busy),     1);
        tick();
        checkOutput("scan.up2",     32'(motor_up), 1);
        checkOutput("scan.target6", 32'(target),   6);
        at_floor = 1'b0; position = 4'd5;
        tick();
        at_floor = 1'b1;
        tick();
        checkOutput("scan.pass5", 32'(motor_up), 1);
        position = 4'd6;
        tick();
        checkOutput("scan.stop6.door",    32'(door),    1);
        checkOutput("scan.stop6.pending", 32'(pending), 32'h02);
        checkOutput("scan.stop6.target",  32'(target),  6);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("scan.idle6.motor_down", 32'(motor_down), 0);
        tick();
        checkOutput("scan.down",    32'(motor_down), 1);
        checkOutput("scan.down.up", 32'(motor_up),   0);
        checkOutput("scan.target1", 32'(target),     1);
        at_floor = 1'b0; position = 4'd3;
        tick();
        position = 4'd1; at_floor = 1'b1;
        tick();
        checkOutput("scan.stop1.door",       32'(door),       1);
        checkOutput("scan.stop1.motor_down", 32'(motor_down), 0);
        checkOutput("scan.stop1.pending",    32'(pending),    0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("scan.end.door", 32'(door), 0);
        checkOutput("scan.end.busy", 32'(busy), 0);

        // Same floor from hall and cabin in one cycle: one bit, one stop
        applyStimulus(1'b1, 4'd3, 1'b1, 4'd3);
        checkOutput("dup.pending", 32'(pending), 32'h08);
        tick();
        checkOutput("dup.up",     32'(motor_up), 1);
        checkOutput("dup.target", 32'(target),   3);
        position = 4'd3;
        tick();
        checkOutput("dup.door",    32'(door),    1);
        checkOutput("dup.pending0", 32'(pending), 0);
        for (int i = 0; i < 4; i++) tick();
        tick();
        checkOutput("dup.after.up",   32'(motor_up),   0);
        checkOutput("dup.after.down", 32'(motor_down), 0);
        checkOutput("dup.after.busy", 32'(busy),       0);

        // Out-of-range indices are ignored
        applyStimulus(1'b1, 4'd9, 1'b1, 4'd12);
        checkOutput("oor.pending", 32'(pending), 0);
        checkOutput("oor.busy",    32'(busy),    0);

        // Press for the current floor during dwell restarts the full dwell
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd3);
        checkOutput("ext.pending", 32'(pending), 32'h08);
        tick();
        checkOutput("ext.open",     32'(door),    1);
        checkOutput("ext.pending0", 32'(pending), 0);
        tick();
        applyStimulus(1'b1, 4'd3, 1'b0, 4'd0);
        checkOutput("ext.reload.pending", 32'(pending), 0);
        checkOutput("ext.reload.door",    32'(door),    1);
        tick();
        checkOutput("ext.door1", 32'(door), 1);
        tick();
        checkOutput("ext.door2", 32'(door), 1);
        tick();
        checkOutput("ext.door3", 32'(door), 1);
        tick();
        checkOutput("ext.closed", 32'(door), 0);

        // Service disable while moving down from 6 toward 0
        position = 4'd6; at_floor = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd0);
        checkOutput("off.pending", 32'(pending), 32'h01);
        tick();
        checkOutput("off.down",   32'(motor_down), 1);
        checkOutput("off.target", 32'(target),     0);
        at_floor = 1'b0; off_btn = 1'b1;
        applyStimulus(1'b1, 4'd4, 1'b0, 4'd0);
        checkOutput("off.cleared", 32'(pending),    0);
        checkOutput("off.moving",  32'(motor_down), 1);
        checkOutput("off.busy",    32'(busy),       1);
        position = 4'd5; at_floor = 1'b1;
        tick();
        checkOutput("off.stop5.door", 32'(door),       1);
        checkOutput("off.stop5.down", 32'(motor_down), 0);
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd2);
        checkOutput("off.ignore.pending", 32'(pending), 0);
        checkOutput("off.dwell2.door",    32'(door),    1);
        tick();
        checkOutput("off.dwell3.door", 32'(door), 1);
        tick();
        checkOutput("off.dwell4.door", 32'(door), 1);
        tick();
        checkOutput("off.closed.door", 32'(door), 0);
        tick();
        checkOutput("off.idle.busy", 32'(busy),       0);
        checkOutput("off.idle.up",   32'(motor_up),   0);
        checkOutput("off.idle.down", 32'(motor_down), 0);
        off_btn = 1'b0;

        // Reset in the middle of an upward move
        position = 4'd0; at_floor = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1, 4'd2);
        tick();
        at_floor = 1'b0; position = 4'd1;
        tick();
        checkOutput("mid.up",      32'(motor_up), 1);
        checkOutput("mid.pending", 32'(pending),  32'h04);
        reset = 1'b1;
        tick();
        checkOutput("mid.rst.up",      32'(motor_up),   0);
        checkOutput("mid.rst.down",    32'(motor_down), 0);
        checkOutput("mid.rst.door",    32'(door),       0);
        checkOutput("mid.rst.target",  32'(target),     0);
        checkOutput("mid.rst.pending", 32'(pending),    0);
        checkOutput("mid.rst.busy",    32'(busy),       0);
        reset = 1'b0;
        tick();
        checkOutput("mid.post.up",   32'(motor_up), 0);
        checkOutput("mid.post.busy", 32'(busy),     0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler for a single elevator car. It latches hall (floor) and cabin button presses into a pending-floor mask and sequences the car through move-up, move-down and door-dwell phases using a SCAN policy: keep travelling in the current direction while requests remain ahead. It drives the motor and door outputs that the elevator datapath acts on, and takes the car's floor position as feedback.

## Interface
- FLOORS, 8, number of served floors (2..16)
- FLOOR_W, 3, floor index width, ≥ clog2(FLOORS)
- DWELL, 4, cycles the door stays open per stop (≥1)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- off_btn  in  1  service disable: drops pending requests, stops at next floor
- position  in  FLOOR_W  current/last-passed floor index of the car
- at_floor  in  1  car is aligned with `position` this cycle
- floor_req_valid  in  1  hall call strobe, one cycle per press
- floor_req  in  FLOOR_W  hall call floor index
- cabin_req_valid  in  1  cabin button strobe, one cycle per press
- cabin_req  in  FLOOR_W  cabin button floor index
- motor_up  out  1  drive car upward
- motor_down  out  1  drive car downward
- door  out  1  door open
- target  out  FLOOR_W  next stop floor
- pending  out  FLOORS  latched request mask, bit i = floor i requested
- busy  out  1  state ≠ IDLE or pending ≠ 0

## Operation
- Request capture: valid strobe with index < FLOORS sets pending[index]; index ≥ FLOORS ignored. Both strobes in one cycle set both bits (same index → one bit).
- Clear-wins: if pending[k] is cleared (stop at k) on the same edge a request for k arrives, bit ends 0.
- While off_btn=1 all requests are ignored and pending is held at 0.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Register last_dir (reset = up).
- IDLE: if pending[position] & at_floor → DOOR_OPEN, clear bit. Else if pending has bits both above and below position → move in last_dir. Else if any above → MOVE_UP; else if any below → MOVE_DOWN; else stay.
- MOVE_UP: on at_floor & pending[position] → DOOR_OPEN, clear bit, last_dir=up. On at_floor & no pending bit > position → IDLE. Never drive up at position = FLOORS-1 (→ IDLE).
- MOVE_DOWN: mirror image; never drive down at position 0.
- DOOR_OPEN: dwell counter loads DWELL-1 on entry, decrements each cycle, exits to IDLE after it reaches 0. A new request for position while in DOOR_OPEN with at_floor reloads the counter and is not latched.
- off_btn=1: pending cleared; MOVE_* continues until the next at_floor, then DOOR_OPEN; IDLE stays IDLE; DOOR_OPEN completes dwell.
- Outputs are Moore-decoded from state: motor_up = MOVE_UP, motor_down = MOVE_DOWN, door = DOOR_OPEN; never two asserted at once.
- target (registered): MOVE_UP → lowest pending index > position; MOVE_DOWN → highest pending index < position; otherwise position.

## Timing
- Reset (sync, any state, including mid-move): state IDLE, pending 0, last_dir up, dwell counter 0; motor_up=0, motor_down=0, door=0, target=0, busy=0 from the first edge with reset=1.
- Request strobe sampled at edge N → pending bit visible after N → IDLE decision at edge N+1 → motor/door output high after N+1 (2-cycle latency).
- Arrival: at_floor & matching pending bit sampled at edge M → motor low and door high after M; door stays high exactly DWELL cycles.
- After dwell, one IDLE cycle precedes any new move.
- off_btn is sampled each edge; takes effect on the next edge.

## Test plan
- Reset mid-MOVE_UP with pending=0b0100 → after one edge all outputs 0, pending=0, state IDLE.
- position=1, at_floor=1, cabin_req=5 → motor_up high 2 cycles after strobe; at position=5 & at_floor → motor_up low, door high 4 cycles, pending=0.
- Car moving up from 2 with pending {4,6}, hall call 1 → stops at 4, then 6, then reverses to 1 (SCAN order 4,6,1).
- Strobes floor_req=3 and cabin_req=3 in the same cycle → pending=0b1000, a single stop at 3.
- Requests at index 9 with FLOORS=8 → pending unchanged; request for position during DOOR_OPEN → dwell extends to DWELL cycles from that request.
- off_btn asserted while moving down from 6 toward 0 with pending {0} → pending=0, car stops at next at_floor (5), door open 4 cycles, then IDLE; new presses are ignored.
